// File: rtl/serdes_pkg.sv
// serdes_pkg
//   Shared definitions for the 8b/10b link: the K-code byte values used
//   for commas and frame delimiters, and the link sequencer state enum.
//   Imported by the transmit link controller and the receive-side
//   aligner/decoder.
package serdes_pkg;

  localparam logic [7:0] K_COMMA = 8'hBC;  // K28.5, word-alignment comma
  localparam logic [7:0] K_SOF   = 8'hFB;  // K27.7, start of frame
  localparam logic [7:0] K_EOF   = 8'hFD;  // K29.7, end of frame

  typedef enum logic [2:0] {
    ST_TRAIN,
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_EOF
  } link_state_e;

endpackage

// File: rtl/serdes_rr_arbiter.sv
// serdes_rr_arbiter
//   Round-robin arbiter with a one-hot combinational grant. The search
//   starts at the index after the last granted one; the pointer only
//   advances when en is pulsed, so a grant can be evaluated every cycle
//   and committed once per frame.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   req       request vector
//   en        commit the current grant (advances the pointer)
//   grant     one-hot grant, zero when no request is pending
module serdes_rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [IW-1:0] gidx;
  logic          found;

  // Walk N_REQ positions starting just after ptr; first requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IW'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) gidx = IW'(i);
    end
  end

  // Pointer resets to the last index so requester 0 is served first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IW'(N_REQ - 1);
    end else if (en) begin
      ptr <= gidx;
    end
  end

endmodule

// File: rtl/serdes_tx_link_ctrl.sv
// serdes_tx_link_ctrl
//   Transmit link sequencer in front of the 8b/10b serializer. Emits one
//   symbol per clock: comma training after reset/retrain, idle commas,
//   and frames SOF / bytes / EOF taken round-robin from N_REQ requesters.
//   A comma is forced whenever ALIGN_PERIOD non-comma symbols have been
//   sent back to back; the interrupted symbol is simply delayed.
// Ports:
//   i_Clk, i_Rst   word clock, synchronous active-high reset
//   i_Retrain      pulse: abort any frame and restart training
//   i_Req_Valid/Data/Last  per-requester byte stream (byte r at [8r+7:8r])
//   o_Req_Ready    per-requester accept, at most one bit high
//   o_Grant        one-hot owner of the open frame, 0 otherwise
//   o_Data, o_K    registered symbol and control flag to the serializer
//   o_Train        registered, high while training commas are on o_Data
module serdes_tx_link_ctrl
  import serdes_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int TRAIN_LEN    = 16,
  parameter int ALIGN_PERIOD = 64
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Retrain,
  input  logic [N_REQ-1:0]   i_Req_Valid,
  input  logic [8*N_REQ-1:0] i_Req_Data,
  input  logic [N_REQ-1:0]   i_Req_Last,
  output logic [N_REQ-1:0]   o_Req_Ready,
  output logic [N_REQ-1:0]   o_Grant,
  output logic [7:0]         o_Data,
  output logic               o_K,
  output logic               o_Train
);

  localparam int AW = $clog2(ALIGN_PERIOD + 1);
  localparam int TW = $clog2(TRAIN_LEN + 1);

  link_state_e      state, state_nx;
  logic [7:0]       data_p1, data_nx;
  logic             k_p1, k_nx;
  logic             train_p1, train_nx;
  logic [N_REQ-1:0] grant_p1, grant_nx, arb_grant;
  logic [AW-1:0]    align_cnt, align_nx;
  logic [TW-1:0]    train_cnt, train_cnt_nx;

  logic [7:0]       own_data;
  logic             own_valid, own_last;
  logic             forced, ready_any, xfer, start, arb_en, train_done;

  // Byte, valid and last of the current frame owner.
  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int r = 0; r < N_REQ; r++) begin
      if (grant_p1[r]) begin
        own_data  = own_data | i_Req_Data[8*r +: 8];
        own_valid = own_valid | i_Req_Valid[r];
        own_last  = own_last | i_Req_Last[r];
      end
    end
  end

  // Forcing depends only on registered state so ready never looks at valid;
  // in DATA with no byte pending a comma would have gone out anyway.
  assign forced     = (align_cnt == AW'(ALIGN_PERIOD)) &&
                      (state == ST_SOF || state == ST_DATA || state == ST_EOF);
  assign ready_any  = (state == ST_SOF || state == ST_DATA) && !forced;
  assign xfer       = ready_any && own_valid;
  // align_cnt == 0 means a comma is on the line, guaranteeing the gap.
  assign start      = (state == ST_IDLE) && (align_cnt == '0) && (|i_Req_Valid);
  assign arb_en     = start && !i_Retrain;
  assign train_done = (train_cnt == TW'(TRAIN_LEN - 1));

  assign o_Req_Ready = ready_any ? grant_p1 : '0;

  serdes_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .req   (i_Req_Valid),
    .en    (arb_en),
    .grant (arb_grant)
  );

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= ST_TRAIN;
    else       state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    if (i_Retrain) begin
      state_nx = ST_TRAIN;
    end else begin
      case (state)
        ST_TRAIN: if (train_done) state_nx = ST_IDLE;
        ST_IDLE:  if (start) state_nx = ST_SOF;
        ST_SOF:   if (!forced) state_nx = (xfer && own_last) ? ST_EOF : ST_DATA;
        ST_DATA:  if (xfer && own_last) state_nx = ST_EOF;
        ST_EOF:   if (!forced) state_nx = ST_IDLE;
        default:  state_nx = ST_TRAIN;
      endcase
    end
  end

  // Next symbol and counters; default is a comma, which clears align_cnt.
  always_comb begin
    data_nx      = K_COMMA;
    k_nx         = 1'b1;
    train_nx     = 1'b0;
    grant_nx     = grant_p1;
    align_nx     = '0;
    train_cnt_nx = train_cnt;
    if (i_Retrain) begin
      train_nx     = 1'b1;
      grant_nx     = '0;
      train_cnt_nx = '0;
    end else begin
      case (state)
        ST_TRAIN: begin
          train_cnt_nx = train_cnt + TW'(1);
          train_nx     = !train_done;
        end
        ST_IDLE: begin
          if (start) begin
            data_nx  = K_SOF;
            grant_nx = arb_grant;
            align_nx = align_cnt + AW'(1);
          end
        end
        ST_SOF, ST_DATA: begin
          if (xfer) begin
            data_nx  = own_data;
            k_nx     = 1'b0;
            align_nx = align_cnt + AW'(1);
          end
        end
        ST_EOF: begin
          if (!forced) begin
            data_nx  = K_EOF;
            grant_nx = '0;
            align_nx = align_cnt + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output stage
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      data_p1   <= K_COMMA;
      k_p1      <= 1'b1;
      train_p1  <= 1'b1;
      grant_p1  <= '0;
      align_cnt <= '0;
      train_cnt <= '0;
    end else begin
      data_p1   <= data_nx;
      k_p1      <= k_nx;
      train_p1  <= train_nx;
      grant_p1  <= grant_nx;
      align_cnt <= align_nx;
      train_cnt <= train_cnt_nx;
    end
  end

  assign o_Data  = data_p1;
  assign o_K     = k_p1;
  assign o_Train = train_p1;
  assign o_Grant = grant_p1;

endmodule

// File: tb/tb_serdes_tx_link_ctrl.sv
// tb_serdes_tx_link_ctrl
//   Scoreboard bench: drivers push expected bytes per requester and the
//   expected frame owners; a link monitor pops and checks them as symbols
//   appear, and enforces SOF/EOF bracketing, the post-frame comma and the
//   comma run limit. Reset, latency, training and retrain are checked
//   directly against fixed expectations.
module tb_serdes_tx_link_ctrl;

  localparam int N_REQ        = 2;
  localparam int TRAIN_LEN    = 16;
  localparam int ALIGN_PERIOD = 64;

  logic               clk;
  logic               rst;
  logic               retrain;
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic [7:0]         data;
  logic               k;
  logic               train;

  logic       vld_r [N_REQ];
  logic [7:0] dat_r [N_REQ];
  logic       lst_r [N_REQ];

  assign req_valid = {vld_r[1], vld_r[0]};
  assign req_data  = {dat_r[1], dat_r[0]};
  assign req_last  = {lst_r[1], lst_r[0]};

  serdes_tx_link_ctrl #(
    .N_REQ(N_REQ), .TRAIN_LEN(TRAIN_LEN), .ALIGN_PERIOD(ALIGN_PERIOD)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Retrain   (retrain),
    .i_Req_Valid (req_valid),
    .i_Req_Data  (req_data),
    .i_Req_Last  (req_last),
    .o_Req_Ready (req_ready),
    .o_Grant     (grant),
    .o_Data      (data),
    .o_K         (k),
    .o_Train     (train)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: {last, byte} per requester, and the expected frame owners.
  logic [8:0] exp_q [N_REQ][$];
  int         own_q [$];
  logic [7:0] tab2 [3];

  bit mon_en   = 1'b0;
  bit in_frame = 1'b0;
  bit exp_eof  = 1'b0;
  bit exp_gap  = 1'b0;
  int own      = 0;
  int run      = 0;
  int max_run  = 0;
  int fill_cnt = 0;

  // Link monitor
  initial begin
    logic       is_c;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        is_c = k && (data == 8'hBC);
        if (is_c) run = 0;
        else      run++;
        if (run > max_run) max_run = run;
        if (run > ALIGN_PERIOD) check_eq("align_run", run, ALIGN_PERIOD);
        if (in_frame && run == ALIGN_PERIOD) check_eq("forced_ready", req_ready, 0);
        if (exp_eof) begin
          check_eq("eof_sym", {k, data}, {1'b1, 8'hFD});
          check_eq("eof_grant", grant, 0);
          exp_eof  = 1'b0;
          in_frame = 1'b0;
          exp_gap  = 1'b1;
        end else if (exp_gap) begin
          check_eq("gap_comma", is_c, 1);
          exp_gap = 1'b0;
        end else if (!in_frame) begin
          if (!is_c) begin
            check_eq("sof_sym", {k, data}, {1'b1, 8'hFB});
            check_eq("own_q", own_q.size() > 0, 1);
            if (own_q.size() > 0) own = own_q.pop_front();
            check_eq("sof_grant", grant, 1 << own);
            in_frame = 1'b1;
          end
        end else if (is_c) begin
          fill_cnt++;
          check_eq("fill_grant", grant, 1 << own);
        end else begin
          check_eq("byte_q", exp_q[own].size() > 0, 1);
          if (exp_q[own].size() > 0) begin
            e = exp_q[own].pop_front();
            check_eq("byte", {k, data}, {1'b0, e[7:0]});
            check_eq("byte_grant", grant, 1 << own);
            if (e[8]) exp_eof = 1'b1;
          end
        end
      end
    end
  end

  // Drive one frame on requester r; entered and left at posedge+1.
  // gap_at drops valid for 3 cycles before that byte index.
  task automatic send_frame(input int r, input int len, input int base,
                            input int gap_at, input bit use_tab);
    bit got;
    for (int i = 0; i < len; i++) begin
      if (i == gap_at) begin
        vld_r[r] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      dat_r[r] = use_tab ? tab2[i] : 8'(base + i);
      lst_r[r] = (i == len - 1);
      vld_r[r] = 1'b1;
      exp_q[r].push_back({lst_r[r], dat_r[r]});
      got = 1'b0;
      for (int w = 0; w < 400 && !got; w++) begin
        @(negedge clk);
        if (req_ready[r]) got = 1'b1;
      end
      check_eq("handshake", got, 1);
      @(posedge clk);
      #1;
    end
    vld_r[r] = 1'b0;
    lst_r[r] = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (10) @(negedge clk);
    check_eq({tag, "_own_q"}, own_q.size(), 0);
    check_eq({tag, "_q0"}, exp_q[0].size(), 0);
    check_eq({tag, "_q1"}, exp_q[1].size(), 0);
    check_eq({tag, "_closed"}, in_frame, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         tcnt, bad, gbad, fd_seen;
    bit         found;
    logic [7:0] p2_d [5];
    logic       p2_k [5];
    logic [1:0] p2_g [5];

    tab2[0] = 8'hAA; tab2[1] = 8'h55; tab2[2] = 8'h01;
    p2_d[0] = 8'hAA; p2_d[1] = 8'h55; p2_d[2] = 8'h01; p2_d[3] = 8'hFD; p2_d[4] = 8'hBC;
    p2_k[0] = 1'b0;  p2_k[1] = 1'b0;  p2_k[2] = 1'b0;  p2_k[3] = 1'b1;  p2_k[4] = 1'b1;
    p2_g[0] = 2'b01; p2_g[1] = 2'b01; p2_g[2] = 2'b01; p2_g[3] = 2'b00; p2_g[4] = 2'b00;

    rst     = 1'b1;
    retrain = 1'b0;
    for (int r = 0; r < N_REQ; r++) begin
      vld_r[r] = 1'b0; dat_r[r] = 8'h00; lst_r[r] = 1'b0;
    end

    // Reset values and training burst
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_data", data, 8'hBC);
    check_eq("rst_k", k, 1);
    check_eq("rst_train", train, 1);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tcnt = 0;
    bad  = 0;
    for (int i = 0; i < TRAIN_LEN + 4; i++) begin
      @(negedge clk);
      if (train && tcnt == i) tcnt++;
      if (!(k && data == 8'hBC)) bad++;
    end
    check_eq("train_len", tcnt, TRAIN_LEN);
    check_eq("train_comma", bad, 0);
    @(negedge clk);
    check_eq("idle_sym", {k, data}, {1'b1, 8'hBC});
    check_eq("idle_train", train, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Single frame from requester 0 with exact timing
    own_q.push_back(0);
    fork
      send_frame(0, 3, 0, -1, 1'b1);
      begin
        @(negedge clk);
        @(negedge clk);
        check_eq("sof_latency", {k, data}, {1'b1, 8'hFB});
        check_eq("sof_ready", req_ready, 2'b01);
        check_eq("sof_grant0", grant, 2'b01);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check_eq("p2_sym", {k, data}, {p2_k[i], p2_d[i]});
          check_eq("p2_grant", grant, p2_g[i]);
        end
      end
    join
    drain("p2");

    // Both requesters stream 2-byte frames; pointer now sits at 0
    own_q.push_back(1); own_q.push_back(0);
    own_q.push_back(1); own_q.push_back(0);
    own_q.push_back(1); own_q.push_back(0);
    fork
      for (int f = 0; f < 3; f++) send_frame(0, 2, 8'h10 + 2 * f, -1, 1'b0);
      for (int f = 0; f < 3; f++) send_frame(1, 2, 8'h80 + 2 * f, -1, 1'b0);
    join
    drain("p3");

    // Long frame from requester 1 exercises forced alignment comma
    max_run = 0;
    own_q.push_back(1);
    send_frame(1, 100, 0, -1, 1'b0);
    drain("p4");
    check_eq("max_run", max_run, ALIGN_PERIOD);

    // Valid gap mid-frame gives filler commas
    fill_cnt = 0;
    own_q.push_back(0);
    send_frame(0, 5, 8'h40, 2, 1'b0);
    drain("p5");
    check_eq("fill_cnt", fill_cnt, 3);

    // Retrain mid-frame
    mon_en = 1'b0;
    vld_r[0] = 1'b1; dat_r[0] = 8'hE0; lst_r[0] = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge clk);
      if (grant == 2'b01) found = 1'b1;
    end
    check_eq("rt_owner0", found, 1);
    @(posedge clk);
    #1;
    vld_r[1] = 1'b1; dat_r[1] = 8'h77; lst_r[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    retrain = 1'b1;
    @(posedge clk);
    #1;
    retrain = 1'b0;
    tcnt = 0; gbad = 0; fd_seen = 0;
    for (int i = 0; i <= TRAIN_LEN; i++) begin
      @(negedge clk);
      if (train && tcnt == i) tcnt++;
      if (grant != 0) gbad++;
      if (k && data == 8'hFD) fd_seen++;
    end
    check_eq("rt_train_len", tcnt, TRAIN_LEN);
    check_eq("rt_grant_clear", gbad, 0);
    check_eq("rt_no_eof", fd_seen, 0);
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge clk);
      if (k && data == 8'hFB) found = 1'b1;
    end
    check_eq("rt_sof", found, 1);
    check_eq("rt_rr_grant", grant, 2'b10);
    check_eq("rt_ready1", req_ready, 2'b10);
    @(posedge clk);
    #1;
    vld_r[0] = 1'b0;
    vld_r[1] = 1'b0;
    @(negedge clk);
    check_eq("rt_byte", {k, data}, {1'b0, 8'h77});
    @(negedge clk);
    check_eq("rt_eof", {k, data}, {1'b1, 8'hFD});
    check_eq("rt_eof_grant", grant, 0);
    @(negedge clk);
    check_eq("rt_gap", {k, data}, {1'b1, 8'hBC});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serdes_tx_link_ctrl.md
# serdes_tx_link_ctrl

Transmit-side link controller that sequences the 8b/10b serializer. It merges framed byte streams from `N_REQ` requesters onto the single serializer word input using round-robin arbitration, with one decision per frame. It brackets each frame with control symbols, fills idle and gap cycles with K28.5 commas, forces periodic commas for receiver word alignment, and runs a comma training burst after reset or on a retrain request. It sits directly in front of the serializer and emits exactly one symbol (byte + K flag) per `i_Clk` cycle.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (2..8).
- `TRAIN_LEN`, 16, number of K28.5 symbols in a training burst.
- `ALIGN_PERIOD`, 64, maximum number of consecutive non-K28.5 symbols on the link.

Ports:
- `i_Clk`  in  1  word clock; the serializer's slow clock.
- `i_Rst`  in  1  synchronous reset, active-high.
- `i_Retrain`  in  1  single-cycle pulse that restarts training.
- `i_Req_Valid`  in  N_REQ  per-requester byte valid.
- `i_Req_Data`  in  8*N_REQ  per-requester byte; requester r uses bits [8r+7:8r].
- `i_Req_Last`  in  N_REQ  marks the final byte of a frame.
- `o_Req_Ready`  out  N_REQ  byte accepted when valid & ready; at most one bit high.
- `o_Grant`  out  N_REQ  one-hot owner of the current frame; 0 when no frame is open.
- `o_Data`  out  8  symbol to the serializer.
- `o_K`  out  1  1 = `o_Data` is a control symbol.
- `o_Train`  out  1  high while the training burst is on `o_Data`.

## Operation
- Control symbols (K=1): COMMA = 8'hBC (K28.5), SOF = 8'hFB (K27.7), EOF = 8'hFD (K29.7).
- States:
  - TRAIN: emit COMMA `TRAIN_LEN` times, then go to IDLE.
  - IDLE: emit COMMA. If any valid is high, arbitrate and go to SOF.
  - SOF: emit SOF, then go to DATA.
  - DATA: transfer bytes from the owner. Emit COMMA filler on any cycle with no transfer. A transfer with last=1 goes to EOF.
  - EOF: emit EOF, clear `o_Grant`, then go to IDLE.
- Minimum one COMMA between frames.
- Arbitration: round-robin starting after the last granted index. The pointer resets to `N_REQ-1`, so requester 0 wins first. The grant holds until EOF; other valids are ignored during a frame.
- `o_Req_Ready[g]` = owner g & (state is SOF or DATA) & no forced comma this cycle. Combinational from registered state only; does not depend on `i_Req_Valid`.
- Forced alignment:
  - `align_cnt` counts consecutive non-COMMA symbols on `o_Data`.
  - If the next symbol would make it exceed `ALIGN_PERIOD`, register COMMA instead, hold state, and deassert ready that cycle.
  - A pending SOF or EOF is deferred one cycle. No byte is lost.
- `i_Retrain`: from any state, go to TRAIN on the next edge and restart the burst count. An open frame is aborted: no EOF, grant cleared. The arbitration pointer is kept.
- `i_Rst` has priority over `i_Retrain`.

## Timing
- Reset values: `o_Data`=8'hBC, `o_K`=1, `o_Train`=1, `o_Grant`=0, `o_Req_Ready`=0, state TRAIN, counters 0.
- `o_Data`, `o_K`, `o_Train` and `o_Grant` are registered.
- After reset release, the first `TRAIN_LEN` cycles show COMMA with `o_Train`=1.
- A valid seen in IDLE at cycle t produces SOF on `o_Data` at t+1, and ready is high at t+1.
- A byte transferred at cycle c appears on `o_Data` at c+1 (latency 1).
- A last transfer at c gives EOF at c+2, then at least one COMMA follows.
- Back-to-back frames: a frame of L bytes uses L+3 symbols (SOF, L bytes, EOF, COMMA).
- `align_cnt` resets to 0 on every COMMA emitted, including filler and idle commas.
- A forced comma counts as a no-transfer cycle.

## Structure
- Package `serdes_pkg` holds the K-code constants (COMMA, SOF, EOF) and the state enum (TRAIN, IDLE, SOF, DATA, EOF); it is shared with the receive-side aligner and decoder.
- Sub-module `serdes_rr_arbiter`: parameterized `N_REQ` round-robin arbiter with a one-hot grant and an update enable pulsed on grant. Everything else lives in the top module.

## Test plan
- Reset release, no requests → 16 COMMA with `o_Train`=1, then continuous 8'hBC, K=1, `o_Train`=0.
- Requester 0 sends frame AA,55,01 (last on 01) → `o_Data` FB,AA,55,01,FD,BC with K=1,0,0,0,1,1; `o_Grant`=01 for the frame, then 00.
- Both requesters stream 2-byte frames continuously → grants alternate 0,1,0,1; every frame is bracketed by FB/FD with ≥1 BC between frames.
- Requester 1 sends 100 bytes 00..63 with `ALIGN_PERIOD`=64 → a COMMA is inserted after 64 consecutive non-COMMA symbols (SOF + 63 bytes); all 100 bytes arrive in order; ready is low on the inserted cycle.
- Valid drops for 3 cycles mid-frame → 3 BC filler symbols, frame resumes, grant unchanged.
- `i_Retrain` pulse mid-frame → 16 COMMA with `o_Train`=1, no FD emitted, grant 0. Then the waiting requester wins next per the round-robin pointer.
